// File: rtl/mba_pkg.sv
// Shared types and sizing helpers for the multi-byte add sequencer.
package mba_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Byte counter width; a single-byte build still needs a 1-bit counter.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// 8-bit ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module ripple_carry_adder
   import mba_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              cin,
   output logic [BYTE_W-1:0] sum,
   output logic              cout
);

   logic [BYTE_W:0] c;

   assign c[0] = cin;

   generate
      for (genvar gi = 0; gi < BYTE_W; gi++) begin : g_fa
         assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
         assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign cout = c[BYTE_W];

endmodule

// File: rtl/multi_byte_add_ctrl.sv
// Byte-serial W-bit adder built around one 8-bit ripple_carry_adder, with valid/ready in and out.
// Optional MBA_SUB_EN adds a 'sub' port selecting A-B (B inverted, initial carry forced to 1).
module multi_byte_add_ctrl
   import mba_pkg::*;
#(
   parameter int N_BYTES = 4,
   localparam int W      = BYTE_W * N_BYTES
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         cin_in,
`ifdef MBA_SUB_EN
   input  logic         sub,
`endif
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] result,
   output logic         cout_out,
   output logic         busy
);

   localparam int CW = cnt_w(N_BYTES);

   state_e        state_q, state_d;
   logic [W-1:0]  a_sh_q, a_sh_d;
   logic [W-1:0]  b_sh_q, b_sh_d;
   logic [W-1:0]  result_q, result_d;
   logic          carry_q, carry_d;
   logic          cout_q, cout_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [BYTE_W-1:0] add_sum;
   logic              add_cout;
   logic [W-1:0]      b_load;
   logic              carry_load;

   ripple_carry_adder u_rca (
      .a    (a_sh_q[BYTE_W-1:0]),
      .b    (b_sh_q[BYTE_W-1:0]),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Subtraction is A + ~B + 1, so B is stored already inverted.
`ifdef MBA_SUB_EN
   assign b_load     = sub ? ~op_b : op_b;
   assign carry_load = sub ? 1'b1 : cin_in;
`else
   assign b_load     = op_b;
   assign carry_load = cin_in;
`endif

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      result_d = result_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start_valid) begin
               a_sh_d  = op_a;
               b_sh_d  = b_load;
               carry_d = carry_load;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            result_d = (result_q >> BYTE_W) | (W'(add_sum) << (W - BYTE_W));
            a_sh_d   = a_sh_q >> BYTE_W;
            b_sh_d   = b_sh_q >> BYTE_W;
            carry_d  = add_cout;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(N_BYTES - 1)) begin
               cout_d  = add_cout;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
      end
   end

   // start_ready is gated by rst_n so it stays low for the whole reset pulse.
   assign start_ready = rst_n && (state_q == ST_IDLE);
   assign res_valid   = (state_q == ST_DONE);
   assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign result      = result_q;
   assign cout_out    = cout_q;

endmodule

// File: tb/tb_multi_byte_add_ctrl.sv
// Self-checking bench for multi_byte_add_ctrl (N_BYTES=4): vector table, corner sequences, random ops.
module tb_multi_byte_add_ctrl;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin_in;
   logic         sub;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] result;
   logic         cout_out;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   multi_byte_add_ctrl #(.N_BYTES(NB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .cin_in      (cin_in),
`ifdef MBA_SUB_EN
      .sub         (sub),
`endif
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .result      (result),
      .cout_out    (cout_out),
      .busy        (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain wide arithmetic on the operands as the user sees them.
   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic s);
      logic [W:0] r;
      if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      else   r = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      return r;
   endfunction

   // Called at a negedge; returns at a negedge after the result has been taken.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input int hold,
                         output logic [W-1:0] r, output logic co, output int lat);
      int n;
      start_valid = 1'b1; op_a = a; op_b = b; cin_in = c; sub = s;
      n = 0;
      while (!start_ready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) check("start_ready_timeout", 64'(start_ready), 64'd1);
      @(posedge clk); #1;
      start_valid = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (res_valid) break;
      end
      r  = result;
      co = cout_out;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid",  64'(res_valid),   64'd1);
         check("hold_result", 64'(result),      64'(r));
         check("hold_sready", 64'(start_ready), 64'd0);
      end
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check("valid_drop", 64'(res_valid), 64'd0);
      check("idle_ready", 64'(start_ready), 64'd1);
      @(negedge clk);
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] exp_res;
      logic         exp_cout;
   } vec_t;

   vec_t vecs[8];
   int   n_vec;

   initial begin
      logic [W-1:0] r;
      logic         co;
      int           lat;
      logic [W:0]   exp;
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      int           n;

      rst_n = 1'b0; start_valid = 1'b0; op_a = '0; op_b = '0;
      cin_in = 1'b0; sub = 1'b0; res_ready = 1'b0;

      n_vec = 0;
      vecs[n_vec++] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0};
      vecs[n_vec++] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1};
      vecs[n_vec++] = '{32'h000000F4, 32'h0000000B, 1'b1, 1'b0, 32'h00000100, 1'b0};
      vecs[n_vec++] = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h00000001, 1'b1};
      vecs[n_vec++] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0};
`ifdef MBA_SUB_EN
      vecs[n_vec++] = '{32'h00000006, 32'h00000005, 1'b0, 1'b1, 32'h00000001, 1'b1};
      vecs[n_vec++] = '{32'h00000005, 32'h00000006, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0};
`endif

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_sready", 64'(start_ready), 64'd0);
      check("rst_valid",  64'(res_valid),   64'd0);
      check("rst_busy",   64'(busy),        64'd0);
      check("rst_result", 64'(result),      64'd0);
      check("rst_cout",   64'(cout_out),    64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_sready", 64'(start_ready), 64'd1);

      // Vector table
      for (int i = 0; i < n_vec; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1, r, co, lat);
         check($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].exp_res));
         check($sformatf("vec%0d_cout", i),   64'(co), 64'(vecs[i].exp_cout));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(NB));
         $display("vec %0d: a=%h b=%h cin=%0d sub=%0d -> result=%h cout=%0d lat=%0d",
                  i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, r, co, lat);
      end

      // Backpressure plus an ignored start pulse during RUN
      start_valid = 1'b1; op_a = 32'h7F; op_b = 32'h1; cin_in = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
      start_valid = 1'b0;
      @(negedge clk);
      check("run_busy",   64'(busy),        64'd1);
      check("run_sready", 64'(start_ready), 64'd0);
      start_valid = 1'b1; op_a = 32'hAAAA_AAAA; op_b = 32'h5555_5555;
      @(negedge clk);
      start_valid = 1'b0;
      n = 0;
      while (!res_valid && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) check("bp_valid_timeout", 64'(res_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         check("bp_result", 64'(result),      64'h80);
         check("bp_valid",  64'(res_valid),   64'd1);
         check("bp_sready", 64'(start_ready), 64'd0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("bp_no_second_op", 64'(busy), 64'd0);
      end
      $display("backpressure: result=%h held 10 cycles", result);

      // Asynchronous reset two cycles into RUN
      start_valid = 1'b1; op_a = 32'h12345678; op_b = 32'h11111111; cin_in = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("arst_result", 64'(result),      64'd0);
      check("arst_cout",   64'(cout_out),    64'd0);
      check("arst_valid",  64'(res_valid),   64'd0);
      check("arst_busy",   64'(busy),        64'd0);
      check("arst_sready", 64'(start_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(32'd6, 32'd5, 1'b0, 1'b0, 0, r, co, lat);
      check("post_rst_result", 64'(r),  64'd11);
      check("post_rst_cout",   64'(co), 64'd0);
      $display("after reset: 6+5 -> result=%0d cout=%0d", r, co);

      // Random operations against the reference
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom);
`ifdef MBA_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         if (i % 50 == 0) ra = '1;
         run_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), r, co, lat);
         exp = ref_sum(ra, rb, rc, rs);
         check("rand_sum",     64'({co, r}), 64'(exp));
         check("rand_latency", 64'(lat),     64'(NB));
         $display("rand %0d: a=%h b=%h cin=%0d sub=%0d -> %0d_%h (ref %0d_%h)",
                  i, ra, rb, rc, rs, co, r, exp[W], exp[W-1:0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
